// File: rtl/fp16_feeder_pkg.sv
// fp16_feeder_pkg
// Shared definitions for the fp16 MAC feeder: the controller state type,
// the fp16 constants it drives or inspects, and a small helper that spots
// an all-ones exponent (NaN or infinity).
// No ports (package).
package fp16_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

  localparam logic [15:0] FP16_ZERO    = 16'h0000;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

  // True for NaN and infinity alike; both make the dot product meaningless.
  function automatic logic fp16_exp_is_max(input logic [15:0] value);
    return value[14:10] == FP16_EXP_MAX;
  endfunction

endpackage

// File: rtl/fp16_pair_fifo.sv
// fp16_pair_fifo
// Operand-pair FIFO: DEPTH entries of 32 bits ({a, b}), first-word
// fall-through read so the head pair is visible on rdata while not empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata   write one entry (ignored while full)
//   pop, rdata    remove the head entry (ignored while empty) / head entry
//   full, empty   occupancy status
module fp16_pair_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [31:0] mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Same index with differing wrap bits means the writer is a lap ahead.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fp16_mac_feeder.sv
// fp16_mac_feeder
// Buffers fp16 operand pairs and, on a start request, streams `len` of them
// into an external multiply-accumulate unit: one clear cycle, the pairs
// (zero bubbles whenever the FIFO runs dry), DRAIN_CYC zero cycles to flush
// the MAC pipeline, then the accumulator is captured into result with a
// one-cycle done pulse.
// Optional feature: define FP16_FEEDER_NAN_DET_EN to get a sticky nan_flag
// raised when any streamed operand has an all-ones exponent (cleared when
// the next start is accepted). Without it nan_flag is tied low.
// Ports:
//   CLK, RESETn                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b    operand-pair push channel
//   start, len                     dot-product request and pair count
//   mac_a, mac_b, mac_clr_n        registered operands and accumulator clear
//   acc_in                         accumulator value from the MAC
//   result, done, busy, nan_flag   dot-product result and status
module fp16_mac_feeder
  import fp16_feeder_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_clr_n,
  input  logic [15:0]      acc_in,
  output logic [15:0]      result,
  output logic             done,
  output logic             busy,
  output logic             nan_flag
);

  localparam int DRAIN_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  feeder_state_e      state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [15:0]        mac_a_q, mac_a_d;
  logic [15:0]        mac_b_q, mac_b_d;
  logic               mac_clr_n_q, mac_clr_n_d;
  logic [15:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               zero_len_q, zero_len_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [31:0]        fifo_rdata;

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != ST_IDLE);
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_clr_n = mac_clr_n_q;
  assign result    = result_q;
  assign done      = done_q;

  fp16_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (in_valid && in_ready),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Every registered output is computed for the state being entered, so
  // mac_clr_n is low exactly while the FSM sits in CLEAR and the operands
  // default to fp16 zero unless a pair is popped this cycle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    drain_cnt_d = drain_cnt_q;
    mac_a_d     = FP16_ZERO;
    mac_b_d     = FP16_ZERO;
    mac_clr_n_d = 1'b1;
    result_d    = result_q;
    done_d      = 1'b0;
    zero_len_d  = zero_len_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d     = ST_CLEAR;
            count_d     = len;
            zero_len_d  = 1'b0;
            mac_clr_n_d = 1'b0;
          end else begin
            state_d    = ST_DONE;
            zero_len_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          mac_a_d  = fifo_rdata[31:16];
          mac_b_d  = fifo_rdata[15:0];
          count_d  = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_W'(DRAIN_CYC);
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        if (drain_cnt_q == DRAIN_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A zero-length request never touched the MAC, so its answer is +0.
        result_d = zero_len_q ? FP16_ZERO : acc_in;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      drain_cnt_q <= '0;
      mac_a_q     <= FP16_ZERO;
      mac_b_q     <= FP16_ZERO;
      mac_clr_n_q <= 1'b1;
      result_q    <= FP16_ZERO;
      done_q      <= 1'b0;
      zero_len_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      drain_cnt_q <= drain_cnt_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_clr_n_q <= mac_clr_n_d;
      result_q    <= result_d;
      done_q      <= done_d;
      zero_len_q  <= zero_len_d;
    end
  end

`ifdef FP16_FEEDER_NAN_DET_EN
  logic nan_q, nan_d;

  // Sticky across the whole request; only a newly accepted start clears it.
  always_comb begin
    nan_d = nan_q;
    if (state_q == ST_IDLE && start) begin
      nan_d = 1'b0;
    end else if (fifo_pop &&
                 (fp16_exp_is_max(fifo_rdata[31:16]) ||
                  fp16_exp_is_max(fifo_rdata[15:0]))) begin
      nan_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) nan_q <= 1'b0;
    else         nan_q <= nan_d;
  end

  assign nan_flag = nan_q;
`else
  assign nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_mac_feeder.sv
// tb_fp16_mac_feeder
// Self-checking bench for fp16_mac_feeder. A small integer-valued MAC sits
// on the DUT's operand outputs and feeds acc_in back. A transaction-level
// reference (pair queue, job phases counted in cycles, running sum of
// products) predicts every output, and a compare process checks the DUT
// against it on each falling clock edge. Directed scenarios pin key
// latencies and results with literal values; a randomized phase follows.
// Honors FP16_FEEDER_NAN_DET_EN the same way as the design.
module tb_fp16_mac_feeder;

  localparam int DEPTH     = 8;
  localparam int LEN_W     = 8;
  localparam int DRAIN_CYC = 4;
`ifdef FP16_FEEDER_NAN_DET_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESETn = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic             mac_clr_n;
  logic [15:0]      acc_in;
  logic [15:0]      result;
  logic             done;
  logic             busy;
  logic             nan_flag;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 CLK = ~CLK;

  fp16_mac_feeder #(
    .DEPTH     (DEPTH),
    .LEN_W     (LEN_W),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .start     (start),
    .len       (len),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr_n (mac_clr_n),
    .acc_in    (acc_in),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .nan_flag  (nan_flag)
  );

  // Integer-valued fp16 helpers; all bench operands are small integers so
  // every sum stays exactly representable.
  function automatic logic [15:0] int_to_fp16(input int n);
    int e;
    logic [15:0] h;
    if (n <= 0) return 16'h0000;
    if (n > 2047) return 16'h7C00;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    h[15]    = 1'b0;
    h[14:10] = 5'(e + 15);
    h[9:0]   = 10'(n << (10 - e));
    return h;
  endfunction

  function automatic int fp16_to_int(input logic [15:0] h);
    int e;
    int m;
    if (h[14:10] == 5'd0) return 0;
    m = int'(h[9:0]) | 32'h400;
    e = int'(h[14:10]) - 15;
    if (e < 0) return 0;
    if (e >= 10) return m << (e - 10);
    return m >> (10 - e);
  endfunction

  // Behavioural one-cycle MAC closing the loop around the DUT.
  int acc_val;
  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn)         acc_val <= 0;
    else if (!mac_clr_n) acc_val <= 0;
    else                 acc_val <= acc_val + fp16_to_int(mac_a) * fp16_to_int(mac_b);
  end
  assign acc_in = int_to_fp16(acc_val);

  // Reference model state
  logic [31:0] mq[$];
  int          m_phase;
  int          m_rem;
  int          m_drain;
  int          m_sum;
  bit          m_zero;
  logic [15:0] e_a, e_b, e_result;
  logic        e_clr_n, e_done, e_nan;

  task automatic modelReset();
    mq.delete();
    m_phase  = 0;
    m_rem    = 0;
    m_drain  = 0;
    m_sum    = 0;
    m_zero   = 1'b0;
    e_a      = 16'h0000;
    e_b      = 16'h0000;
    e_result = 16'h0000;
    e_clr_n  = 1'b1;
    e_done   = 1'b0;
    e_nan    = 1'b0;
  endtask

  // Phases: 0 idle, 1 clear, 2 stream, 3 drain, 4 finishing.
  task automatic modelStep();
    bit accept;
    logic [31:0] pr;
    accept  = in_valid && (mq.size() < DEPTH);
    e_done  = 1'b0;
    e_a     = 16'h0000;
    e_b     = 16'h0000;
    e_clr_n = 1'b1;
    case (m_phase)
      0: if (start) begin
        e_nan = 1'b0;
        if (len != 0) begin
          m_phase = 1;
          m_rem   = int'(len);
          m_sum   = 0;
          m_zero  = 1'b0;
          e_clr_n = 1'b0;
        end else begin
          m_phase = 4;
          m_zero  = 1'b1;
        end
      end
      1: m_phase = 2;
      2: if (mq.size() > 0) begin
        pr    = mq.pop_front();
        e_a   = pr[31:16];
        e_b   = pr[15:0];
        m_sum = m_sum + fp16_to_int(e_a) * fp16_to_int(e_b);
        if (NAN_EN && (e_a[14:10] == 5'h1F || e_b[14:10] == 5'h1F)) e_nan = 1'b1;
        m_rem--;
        if (m_rem == 0) begin
          m_phase = 3;
          m_drain = DRAIN_CYC;
        end
      end
      3: begin
        m_drain--;
        if (m_drain == 0) m_phase = 4;
      end
      default: begin
        e_done   = 1'b1;
        e_result = m_zero ? 16'h0000 : int_to_fp16(m_sum);
        m_phase  = 0;
      end
    endcase
    if (accept) mq.push_back({in_a, in_b});
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge CLK or negedge RESETn);
      if (!RESETn) modelReset();
      else         modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference model.
  initial begin
    forever begin
      @(negedge CLK);
      checkOutput("in_ready",  16'(in_ready),  16'(mq.size() < DEPTH));
      checkOutput("busy",      16'(busy),      16'(m_phase != 0));
      checkOutput("mac_a",     mac_a,          e_a);
      checkOutput("mac_b",     mac_b,          e_b);
      checkOutput("mac_clr_n", 16'(mac_clr_n), 16'(e_clr_n));
      checkOutput("done",      16'(done),      16'(e_done));
      checkOutput("result",    result,         e_result);
      checkOutput("nan_flag",  16'(nan_flag),  16'(e_nan));
    end
  end

  // Drives one cycle of inputs, then returns just after the sampling edge.
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input int l);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    start    = s;
    len      = LEN_W'(l);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pushPair(input int a, input int b);
    applyStimulus(1'b1, int_to_fp16(a), int_to_fp16(b), 1'b0, 0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 0);
  endtask

  // Counts edges after the start edge until done; an expired budget counts
  // as a failed comparison.
  task automatic waitDone(input int budget, output int edges);
    edges = 0;
    while (edges < budget && !done) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    if (!done) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done", budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;

    // Model pins
    checkOutput("pin_fp16_1",  int_to_fp16(1),  16'h3C00);
    checkOutput("pin_fp16_9",  int_to_fp16(9),  16'h4880);
    checkOutput("pin_fp16_36", int_to_fp16(36), 16'h5080);
    checkOutput("pin_to_int",  16'(fp16_to_int(16'h4800)), 16'd8);

    // Reset values
    #2 RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_busy",      16'(busy),      16'h0);
    checkOutput("rst_done",      16'(done),      16'h0);
    checkOutput("rst_mac_clr_n", 16'(mac_clr_n), 16'h1);
    checkOutput("rst_result",    result,         16'h0000);
    checkOutput("rst_mac_a",     mac_a,          16'h0000);
    RESETn = 1'b1;
    idleCycles(1);
    checkOutput("rst_in_ready", 16'(in_ready), 16'h1);

    $display("[TB] basic two-pair dot product");
    pushPair(1, 2);
    pushPair(3, 2);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 2);
    checkOutput("clear_low", 16'(mac_clr_n), 16'h0);
    idleCycles(1);
    checkOutput("clear_one_cycle", 16'(mac_clr_n), 16'h1);
    waitDone(40, edges);
    checkOutput("len2_latency", 16'(edges + 1), 16'd8);
    checkOutput("len2_result",  result,         16'h4800);

    $display("[TB] zero-length request");
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 0);
    checkOutput("len0_clr_n", 16'(mac_clr_n), 16'h1);
    waitDone(10, edges);
    checkOutput("len0_latency", 16'(edges), 16'd1);
    checkOutput("len0_result",  result,     16'h0000);

    $display("[TB] fill FIFO then drain");
    for (int i = 1; i <= DEPTH; i++) pushPair(i, 1);
    checkOutput("full_ready", 16'(in_ready), 16'h0);
    pushPair(7, 7);
    checkOutput("full_still", 16'(in_ready), 16'h0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, DEPTH);
    waitDone(60, edges);
    checkOutput("full_latency", 16'(edges), 16'(2 + DEPTH + DRAIN_CYC - 1 + 1));
    checkOutput("full_result",  result,     16'h5080);
    checkOutput("full_ready_back", 16'(in_ready), 16'h1);

    $display("[TB] starved stream");
    pushPair(1, 2);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 3);
    idleCycles(4);
    checkOutput("gap_mac_a", mac_a, 16'h0000);
    idleCycles(2);
    pushPair(2, 2);
    pushPair(3, 1);
    waitDone(40, edges);
    checkOutput("starve_latency", 16'(edges + 8), 16'd14);
    checkOutput("starve_result",  result,         16'h4880);

    $display("[TB] reset mid-stream");
    pushPair(1, 1);
    pushPair(1, 1);
    pushPair(1, 1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 3);
    idleCycles(2);
    #2 RESETn = 1'b0;
    #1;
    checkOutput("mid_rst_busy",  16'(busy),      16'h0);
    checkOutput("mid_rst_mac_a", mac_a,          16'h0000);
    checkOutput("mid_rst_clr_n", 16'(mac_clr_n), 16'h1);
    checkOutput("mid_rst_result", result,        16'h0000);
    checkOutput("mid_rst_done",  16'(done),      16'h0);
    @(posedge CLK);
    #1 RESETn = 1'b1;
    checkOutput("mid_rst_ready", 16'(in_ready), 16'h1);
    pushPair(2, 3);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1);
    waitDone(30, edges);
    checkOutput("post_rst_latency", 16'(edges), 16'(2 + 1 + DRAIN_CYC));
    checkOutput("post_rst_result",  result,     16'h4600);

    $display("[TB] NaN operand");
    applyStimulus(1'b1, 16'h7E00, 16'h3C00, 1'b0, 0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1);
    waitDone(30, edges);
    idleCycles(2);
    checkOutput("nan_sticky", 16'(nan_flag), 16'(NAN_EN));
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 0);
    checkOutput("nan_cleared", 16'(nan_flag), 16'h0);
    waitDone(10, edges);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 9) < 6,
                    int_to_fp16($urandom_range(0, 4)),
                    int_to_fp16($urandom_range(0, 4)),
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 6));
    end
    idleCycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
